sext_rr_arbiter: RTL
====================

# sext_rr_arbiter

Round-robin arbiter that shares one narrow-to-wide port extension unit between `N_REQ` requesters. Each requester presents an `IN_W`-bit value and a per-request signedness flag. The winning value is sign- or zero-extended to `OUT_W` bits and held in a one-entry output register behind a valid/ready handshake. The block sits between narrow signed/unsigned producers and a wide consumer, and it makes the port-extension rule explicit and checkable in one place.

## Interface
Parameters:
- `N_REQ`, default 4: number of requesters. Must be ≥ 1.
- `IN_W`, default 4: requester data width.
- `OUT_W`, default 8: output data width. `OUT_W ≥ IN_W` is an elaboration-time error otherwise.

Ports:
- Clocking and reset: one clock; reset is synchronous and active-low (`clk`, `rst_n`).
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  synchronous active-low reset.
- `req_valid`  in  N_REQ  per-requester request.
- `req_data`  in  N_REQ×IN_W  per-requester value.
- `req_signed`  in  N_REQ  1 = sign-extend this request, 0 = zero-extend.
- `req_ready`  out  N_REQ  one-hot grant; transfer occurs when `req_valid[i] && req_ready[i]`.
- `out_valid`  out  1  output register holds a word.
- `out_ready`  in  1  consumer accepts the word.
- `out_data`  out  OUT_W  extended value.
- `out_src`  out  $clog2(N_REQ) (min 1)  index of the granted requester.
- `out_signed`  out  1  signedness used for `out_data`.

## Operation
- Two-state FSM:
  - EMPTY: `out_valid=0`.
  - FULL: `out_valid=1`.
- Accept condition: `can_load = (state==EMPTY) || out_ready`.
- Arbitration:
  - Combinational.
  - Pointer `rr_ptr` gives the highest-priority index.
  - Scan `rr_ptr, rr_ptr+1, …` mod N_REQ.
  - The first set `req_valid` wins.
- `req_ready[w] = can_load && req_valid[w]` for the winner `w` only. All other bits are 0.
  - `req_ready` is never asserted without `req_valid`.
- On a transfer:
  - `out_data` ← ext(`req_data[w]`, `req_signed[w]`).
  - `out_src` ← w.
  - `out_signed` ← `req_signed[w]`.
  - state → FULL.
  - `rr_ptr` ← (w+1) mod N_REQ, wrapping from N_REQ-1 to 0.
- Extension rule:
  - signed: bits [OUT_W-1:IN_W] = `req_data[w][IN_W-1]`.
  - unsigned: bits [OUT_W-1:IN_W] = 0.
  - Low IN_W bits are copied unchanged.
  - When `OUT_W==IN_W`, data passes through.
- Drain: FULL with `out_ready=1` and no transfer → EMPTY.
- Simultaneous drain and load: the new word replaces the old one in the same edge. State stays FULL and there is no bubble.
- Back-pressure: while FULL and `!out_ready`, `out_data`, `out_src` and `out_signed` hold stable, all `req_ready=0`, and `rr_ptr` holds.
- No requests: `rr_ptr` holds.
- `N_REQ==1`: the pointer is constant 0 and the block degenerates to a registered extender.
- Immediate assertion every cycle with `out_valid`: `out_data[OUT_W-1:IN_W]` equals all-zero, or (when `out_signed`) a replicate of `out_data[IN_W-1]`.

## Timing
- Latency: requester handshake at edge k → `out_valid` with that data from edge k.
- Visible in cycle k+1.
- Throughput: one word per cycle when `out_ready` is held high.
- Reset (`rst_n=0` at an edge) forces:
  - state=EMPTY, `out_valid=0`, `out_data=0`, `out_src=0`, `out_signed=0`, `rr_ptr=0`.
  - Any held word is discarded.
  - Requests presented during reset are not granted: `req_ready=0` while `rst_n=0`.
- First grant is possible on the first edge with `rst_n=1`.

## Structure
- Package `sext_pkg`:
  - function `extend(logic [IN_W-1:0] v, logic s)` returning `OUT_W` bits, parameterised through the package parameters or a parameterised class static.
  - FSM state enum `sext_state_e {EMPTY, FULL}`.
- Sub-module `sext_unit`: purely combinational extender (`in`, `is_signed` → `out`). It is instantiated once after the grant mux and is reusable by other port-width tests.
- Arbiter, pointer and output register live in `sext_rr_arbiter`.

## Test plan
- Signed extend: req0 `4'hd`, signed=1, `out_ready=1` → next cycle `out_valid=1`, `out_data=8'hfd`, `out_src=0`.
- Unsigned extend: req2 `4'hd`, signed=0 → `out_data=8'h0d`, `out_src=2`. Signed `4'h5` → `8'h05`.
- Round-robin fairness: all four requesters valid continuously with `out_ready=1` → grants 0,1,2,3,0,1 on consecutive cycles, with pointer wrap at 3→0.
- Back-pressure: load req1 `4'h8` signed, hold `out_ready=0` for 3 cycles → `out_data=8'hf8` stable, `req_ready=0`. Then raise `out_ready` with req3 valid → req3 loads on the same edge, no bubble.
- Reset mid-operation: FULL with `out_data=8'hfd`, pull `rst_n=0` for one edge → `out_valid=0`, `out_data=0`, pointer 0. After release with req0 and req1 valid, req0 is granted first.
- Degenerate config `N_REQ=1`, `IN_W=OUT_W=8`: input `8'h80` signed → `out_data=8'h80`, assertion passes.

Source files
------------

// File: rtl/sext_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sext_pkg
// Brief    : Shared types and helpers for the sign/zero-extending arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package sext_pkg;

  // Default port widths of the arbiter slice
  localparam int SEXT_IN_W  = 4;
  localparam int SEXT_OUT_W = 8;

  // Output register occupancy
  typedef enum logic [0:0] {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } sext_state_e;

  // Reference extension at the default widths: replicate the MSB when the
  // value is signed, pad with zeros otherwise.
  function automatic logic [SEXT_OUT_W-1:0] extend(input logic [SEXT_IN_W-1:0] v,
                                                   input logic                 s);
    return {{(SEXT_OUT_W-SEXT_IN_W){s & v[SEXT_IN_W-1]}}, v};
  endfunction

endpackage
`default_nettype wire

// File: rtl/sext_unit.sv
`default_nettype none
// ============================================================================
// Module   : sext_unit
// Brief    : Purely combinational sign/zero extender, IN_W -> OUT_W bits.
// Revision : 1.0 - initial release
// ============================================================================
module sext_unit #(
  parameter int IN_W  = 4,
  parameter int OUT_W = 8
) (
  input  logic [IN_W-1:0]  i_in,
  input  logic             i_is_signed,
  output logic [OUT_W-1:0] o_out
);

  if (OUT_W < IN_W) begin : g_bad_width
    $error("sext_unit: OUT_W (%0d) must be >= IN_W (%0d)", OUT_W, IN_W);
    assign o_out = '0;
  end else if (OUT_W == IN_W) begin : g_pass
    // Equal widths: nothing to extend, signedness has no effect
    logic w_unused_sign;
    assign w_unused_sign = i_is_signed;
    assign o_out         = i_in;
  end else begin : g_ext
    // Upper bits copy the input MSB only for signed values
    assign o_out = {{(OUT_W-IN_W){i_is_signed & i_in[IN_W-1]}}, i_in};
  end

endmodule
`default_nettype wire

// File: rtl/sext_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sext_rr_arbiter
// Brief    : Round-robin arbiter feeding one shared extender and a one-entry
//            valid/ready output register.
// Revision : 1.0 - initial release
// ============================================================================
module sext_rr_arbiter
  import sext_pkg::*;
#(
  parameter  int N_REQ = 4,
  parameter  int IN_W  = 4,
  parameter  int OUT_W = 8,
  localparam int SRC_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [N_REQ-1:0]           i_req_valid,
  input  logic [N_REQ-1:0][IN_W-1:0] i_req_data,
  input  logic [N_REQ-1:0]           i_req_signed,
  output logic [N_REQ-1:0]           o_req_ready,
  output logic                       o_out_valid,
  input  logic                       i_out_ready,
  output logic [OUT_W-1:0]           o_out_data,
  output logic [SRC_W-1:0]           o_out_src,
  output logic                       o_out_signed
);

  if (N_REQ < 1) begin : g_bad_nreq
    $error("sext_rr_arbiter: N_REQ (%0d) must be >= 1", N_REQ);
  end

  sext_state_e      r_state;
  sext_state_e      w_state_nxt;
  logic [OUT_W-1:0] r_out_data;
  logic [SRC_W-1:0] r_out_src;
  logic             r_out_signed;

  logic             w_can_load;
  logic             w_grant;
  logic             w_found;
  logic [SRC_W-1:0] w_win;
  logic [N_REQ-1:0] w_onehot;
  logic [IN_W-1:0]  w_sel_data;
  logic             w_sel_signed;
  logic [OUT_W-1:0] w_ext;

  // The register can take a word when empty or when the held word leaves now;
  // requests are never granted while reset is asserted.
  assign w_can_load = (r_state == EMPTY) || i_out_ready;
  assign w_grant    = rst_n && w_can_load && w_found;
  assign o_req_ready = w_grant ? w_onehot : '0;

  if (N_REQ > 1) begin : g_multi
    logic [SRC_W-1:0] r_rr_ptr;
    logic [SRC_W:0]   w_idx;

    // Scan from the pointer upwards with wrap; the first valid request wins
    always_comb begin
      w_found = 1'b0;
      w_win   = '0;
      w_idx   = '0;
      for (int k = 0; k < N_REQ; k++) begin
        w_idx = {1'b0, r_rr_ptr} + (SRC_W+1)'(k);
        if (w_idx >= (SRC_W+1)'(N_REQ)) begin
          w_idx = w_idx - (SRC_W+1)'(N_REQ);
        end
        if (!w_found && i_req_valid[w_idx[SRC_W-1:0]]) begin
          w_found = 1'b1;
          w_win   = w_idx[SRC_W-1:0];
        end
      end
    end

    assign w_onehot     = N_REQ'(1) << w_win;
    assign w_sel_data   = i_req_data[w_win];
    assign w_sel_signed = i_req_signed[w_win];

    // Pointer moves just past the winner on each transfer, otherwise holds
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        r_rr_ptr <= '0;
      end else if (w_grant) begin
        r_rr_ptr <= (w_win == SRC_W'(N_REQ-1)) ? '0 : w_win + SRC_W'(1);
      end
    end
  end else begin : g_single
    // One requester: no pointer, the block is a registered extender
    assign w_found      = i_req_valid[0];
    assign w_win        = '0;
    assign w_onehot     = 1'b1;
    assign w_sel_data   = i_req_data[0];
    assign w_sel_signed = i_req_signed[0];
  end

  sext_unit #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W)
  ) u_ext (
    .i_in        (w_sel_data),
    .i_is_signed (w_sel_signed),
    .o_out       (w_ext)
  );

  // Occupancy state register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next occupancy: a load always leaves the register full (replacing a
  // draining word without a bubble); a drain with no load empties it.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      EMPTY: begin
        if (w_grant) w_state_nxt = FULL;
      end
      FULL: begin
        if (w_grant)          w_state_nxt = FULL;
        else if (i_out_ready) w_state_nxt = EMPTY;
      end
      default: w_state_nxt = EMPTY;
    endcase
  end

  // Output word captures the extended winner on every transfer
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out_data   <= '0;
      r_out_src    <= '0;
      r_out_signed <= 1'b0;
    end else if (w_grant) begin
      r_out_data   <= w_ext;
      r_out_src    <= w_win;
      r_out_signed <= w_sel_signed;
    end
  end

  assign o_out_valid  = (r_state == FULL);
  assign o_out_data   = r_out_data;
  assign o_out_src    = r_out_src;
  assign o_out_signed = r_out_signed;

  if (OUT_W > IN_W) begin : g_chk
    // A held word's upper bits are either zero or a copy of its sign bit
    always_comb begin
      if (r_state == FULL) begin
        assert ((r_out_data[OUT_W-1:IN_W] == '0) ||
                (r_out_signed &&
                 (r_out_data[OUT_W-1:IN_W] == {(OUT_W-IN_W){r_out_data[IN_W-1]}})));
      end
    end
  end

endmodule
`default_nettype wire
